// File: rtl/pattern_vector_sequencer.sv
// LFSR-driven self-test sequencer for one pattern netlist instance.
// Compacts sampled netlist outputs into a 16-bit MISR signature.
module pattern_vector_sequencer #(
  parameter int          NIN       = 11,
  parameter int          NOUT      = 10,
  parameter int          LATENCY   = 2,
  parameter int          INIT_CYC  = 2,
  parameter int          CNT_W     = 16,
  parameter logic [10:0] LFSR_TAPS = 11'h500,
  parameter logic [15:0] MISR_TAPS = 16'hB400
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [NIN-1:0]   seed,
  output logic [NIN-1:0]   dut_in,
  output logic             dut_rst_n,
  input  logic [NOUT-1:0]  dut_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [15:0]      signature,
  output logic [CNT_W-1:0] vec_count
);

  typedef enum logic [2:0] {
    IDLE, INIT, WAIT, CAPTURE, DONE
  } state_t;

  state_t           state;
  logic [NIN-1:0]   lfsr;
  logic [NIN-1:0]   lfsr_next;
  logic [15:0]      misr_next;
  logic [CNT_W-1:0] nv_q;
  logic [15:0]      cnt;
  logic [NIN-1:0]   seed_eff;
  logic [CNT_W-1:0] vc_inc;

  // Next-state datapath for LFSR, MISR and seed substitution.
  always_comb begin
    lfsr_next = lfsr >> 1;
    if (lfsr[0]) lfsr_next = lfsr_next ^ NIN'(LFSR_TAPS);
    misr_next = signature >> 1;
    if (signature[0]) misr_next = misr_next ^ MISR_TAPS;
    misr_next = misr_next ^ 16'(dut_out);
    seed_eff  = (seed == '0) ? '1 : seed;
    vc_inc    = vec_count + 1'b1;
  end

  // Sequencer FSM; abort overrides control but not a capture in flight.
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      state     <= IDLE;
      lfsr      <= '0;
      nv_q      <= '0;
      cnt       <= '0;
      dut_in    <= '0;
      dut_rst_n <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      signature <= '0;
      vec_count <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            nv_q      <= num_vectors;
            lfsr      <= seed_eff;
            dut_in    <= seed_eff;
            signature <= '0;
            vec_count <= '0;
            cnt       <= '0;
            dut_rst_n <= 1'b0;
            busy      <= 1'b1;
            state     <= INIT;
          end
        end
        INIT: begin
          if (cnt == 16'(INIT_CYC - 1)) begin
            cnt       <= '0;
            dut_rst_n <= 1'b1;
            if (nv_q == '0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= WAIT;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT: begin
          if (cnt == 16'(LATENCY - 1)) begin
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        CAPTURE: begin
          signature <= misr_next;
          vec_count <= vc_inc;
          lfsr      <= lfsr_next;
          dut_in    <= lfsr_next;
          if (vc_inc == nv_q) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (abort && state != IDLE) begin
        state     <= IDLE;
        cnt       <= '0;
        dut_rst_n <= 1'b1;
        busy      <= 1'b0;
        done      <= 1'b0;
        aborted   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_vector_sequencer.sv
// Scoreboard bench for pattern_vector_sequencer.
// Netlist outputs come from a small bench-side function of dut_in.
module tb_pattern_vector_sequencer;

  localparam int L = 2;
  localparam int I = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_vectors = '0;
  logic [10:0] seed = '0;
  logic [10:0] dut_in;
  logic        dut_rst_n;
  logic [9:0]  dut_out;
  logic        busy, done, aborted;
  logic [15:0] signature;
  logic [15:0] vec_count;

  int n_chk = 0;
  int n_err = 0;
  int mode = 0;

  logic [10:0] vq[$];

  pattern_vector_sequencer dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_n),
    .start          (start),
    .abort          (abort),
    .num_vectors    (num_vectors),
    .seed           (seed),
    .dut_in         (dut_in),
    .dut_rst_n      (dut_rst_n),
    .dut_out        (dut_out),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .signature      (signature),
    .vec_count      (vec_count)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] net_f(input logic [10:0] v, input int m);
    if (m == 0) return 10'h000;
    if (m == 1) return 10'h001;
    return v[9:0] ^ {v[10], v[10:2]};
  endfunction

  function automatic logic [10:0] lfsr_adv(input logic [10:0] v);
    logic [10:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 11'h500;
    return r;
  endfunction

  function automatic logic [15:0] misr_upd(input logic [15:0] s,
                                           input logic [9:0] d);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r ^ {6'b0, d};
  endfunction

  always_comb dut_out = net_f(dut_in, mode);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic kick(input logic [10:0] sd, input logic [15:0] nv);
    @(posedge clk); #1;
    seed = sd; num_vectors = nv; start = 1'b1;
  endtask

  // Build expected vector queue and signature for a run.
  task automatic plan(input logic [10:0] sd, input int nv, input int upto,
                      output logic [15:0] esig);
    logic [10:0] v;
    v = (sd == 0) ? 11'h7FF : sd;
    esig = '0;
    vq.delete();
    for (int k = 0; k < nv; k++) begin
      vq.push_back(v);
      if (k < upto) esig = misr_upd(esig, net_f(v, mode));
      v = lfsr_adv(v);
    end
  endtask

  task automatic run(input logic [10:0] sd, input int nv, input bit hold);
    logic [15:0] esig;
    logic [10:0] first;
    int dc;
    plan(sd, nv, nv, esig);
    first = (sd == 0) ? 11'h7FF : sd;
    dc = I + nv * (L + 1) + 1;
    kick(sd, 16'(nv));
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= dc; c++) begin
      @(negedge clk);
      if (c <= I) begin
        check("init_rst", {31'd0, dut_rst_n}, 32'd0);
        check("init_busy", {31'd0, busy}, 32'd1);
        if (c == 1) check("first_in", {21'd0, dut_in}, {21'd0, first});
      end else if (c < dc) begin
        check("run_rst", {31'd0, dut_rst_n}, 32'd1);
        if ((c - I - 1) % (L + 1) == L) begin
          if (vq.size() == 0) check("sb_empty", 32'd1, 32'd0);
          else check("vec_in", {21'd0, dut_in}, {21'd0, vq.pop_front()});
        end
      end
      check("done_t", {31'd0, done}, {31'd0, c == dc});
    end
    check("end_busy", {31'd0, busy}, 32'd0);
    check("sig", {16'd0, signature}, {16'd0, esig});
    check("vcnt", {16'd0, vec_count}, nv);
    check("sb_left", vq.size(), 32'd0);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("hold_sig", {16'd0, signature}, {16'd0, esig});
    if (hold) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("reaccept", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("cleanup_ab", {31'd0, aborted}, 32'd1);
    end
  endtask

  initial begin
    logic [15:0] esig;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in", {21'd0, dut_in}, 32'd0);
    check("rst_rstn", {31'd0, dut_rst_n}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sig", {16'd0, signature}, 32'd0);
    check("rst_vc", {16'd0, vec_count}, 32'd0);

    // Reset during WAIT.
    mode = 2;
    kick(11'h123, 16'd4);
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_rstn", {31'd0, dut_rst_n}, 32'd1);
    check("ar_in", {21'd0, dut_in}, 32'd0);
    check("ar_vc", {16'd0, vec_count}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    mode = 0; run(11'h001, 3, 1'b0);
    mode = 1; run(11'h001, 1, 1'b0);
    check("nv1_sig", {16'd0, signature}, 32'h0001);
    run(11'h001, 2, 1'b0);
    check("nv2_sig", {16'd0, signature}, 32'hB401);
    mode = 2; run(11'h000, 2, 1'b0);
    run(11'h3A5, 0, 1'b0);
    run(11'h0F0, 6, 1'b0);
    run(11'h555, 2, 1'b1);

    // Abort and start together in IDLE.
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("idle_ab_busy", {31'd0, busy}, 32'd0);
    check("idle_ab_pulse", {31'd0, aborted}, 32'd0);

    // Abort in the second CAPTURE of a 5-vector run.
    mode = 2;
    plan(11'h2C1, 5, 2, esig);
    kick(11'h2C1, 16'd5);
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("ab_pulse", {31'd0, aborted}, 32'd1);
    check("ab_done", {31'd0, done}, 32'd0);
    check("ab_busy", {31'd0, busy}, 32'd0);
    check("ab_rstn", {31'd0, dut_rst_n}, 32'd1);
    check("ab_vc", {16'd0, vec_count}, 32'd2);
    check("ab_sig", {16'd0, signature}, {16'd0, esig});
    @(negedge clk);
    check("ab_once", {31'd0, aborted}, 32'd0);
    check("ab_nodone", {31'd0, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
